// File: rtl/game_flow_sm.sv
// game_flow_sm: top-level game flow controller (menu, mode select, controls,
// level splash, gameplay, pause, death delay, game-over and game-won screens).
// Ports:
//   clk, resetN                     clock, async active-low reset
//   enter/up/down/pause_key         raw level keys, edge-detected internally
//   one_sec_pulse                   1 Hz single-cycle tick for the countdowns
//   timer_ended/player_died/level_done  gameplay events
//   screen_DR/screen_RGB/RGB_MIF    per-screen draw requests/pixels, background
//   RGBOut, screen_id               registered pixel and active screen
//   game_on, mode_sel, level_sel, lives_left, game_over_type  game status
//   score_reset, lives_reset, level_start  one-cycle strobes
module game_flow_sm #(
   parameter int unsigned NUM_LEVELS  = 2,
   parameter int unsigned NUM_MODES   = 2,
   parameter int unsigned START_LIVES = 3,
   parameter int unsigned SPLASH_SEC  = 2,
   parameter int unsigned DEATH_SEC   = 2
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        enter_key,
   input  logic        up_key,
   input  logic        down_key,
   input  logic        pause_key,
   input  logic        one_sec_pulse,
   input  logic        timer_ended,
   input  logic        player_died,
   input  logic        level_done,
   input  logic [6:0]  screen_DR,
   input  logic [55:0] screen_RGB,
   input  logic [7:0]  RGB_MIF,
   output logic [7:0]  RGBOut,
   output logic [2:0]  screen_id,
   output logic        game_on,
   output logic [((NUM_MODES > 1) ? $clog2(NUM_MODES) : 1)-1:0] mode_sel,
   output logic [$clog2(NUM_LEVELS + 1)-1:0]                    level_sel,
   output logic [3:0]  lives_left,
   output logic [1:0]  game_over_type,
   output logic        score_reset,
   output logic        lives_reset,
   output logic        level_start
);

   localparam int unsigned MODE_W  = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
   localparam int unsigned LEVEL_W = $clog2(NUM_LEVELS + 1);
   localparam int unsigned CNT_MAX = (SPLASH_SEC > DEATH_SEC) ? SPLASH_SEC : DEATH_SEC;
   localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

   localparam logic [3:0] S_MAIN     = 4'd0;
   localparam logic [3:0] S_MODE     = 4'd1;
   localparam logic [3:0] S_CONTROLS = 4'd2;
   localparam logic [3:0] S_LEVEL    = 4'd3;
   localparam logic [3:0] S_PLAY     = 4'd4;
   localparam logic [3:0] S_PAUSE    = 4'd5;
   localparam logic [3:0] S_DYING    = 4'd6;
   localparam logic [3:0] S_OVER     = 4'd7;
   localparam logic [3:0] S_WON      = 4'd8;

   localparam logic [MODE_W-1:0]  MODE_MAX  = MODE_W'(NUM_MODES - 1);
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(NUM_LEVELS);

   logic [3:0]         state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [3:0]         key_raw, key_d, press_q;
   logic               enter_p, up_p, down_p, pause_p;
   logic [2:0]         screen_nxt;
   logic               game_on_nxt;
   logic [MODE_W-1:0]  mode_nxt;
   logic [LEVEL_W-1:0] level_nxt;
   logic [3:0]         lives_nxt, lives_dec;
   logic [1:0]         type_nxt;
   logic               score_reset_nxt, lives_reset_nxt, level_start_nxt;
   logic [7:0]         dr_ext;
   logic [63:0]        rgb_ext;
   logic [7:0]         rgb_nxt;

   // Registered rising-edge detect; key_d resets high so keys held through reset are ignored
   assign key_raw = {pause_key, down_key, up_key, enter_key};
   assign enter_p = press_q[0];
   assign up_p    = press_q[1];
   assign down_p  = press_q[2];
   assign pause_p = press_q[3];

   // Screen 7 (none) maps onto a padded zero draw request, so it always selects RGB_MIF
   assign dr_ext  = {1'b0, screen_DR};
   assign rgb_ext = {8'h00, screen_RGB};
   assign rgb_nxt = dr_ext[screen_id] ? rgb_ext[{screen_id, 3'b000} +: 8] : RGB_MIF;

   // State and registered outputs
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state          <= S_MAIN;
         cnt            <= '0;
         key_d          <= '1;
         press_q        <= '0;
         RGBOut         <= '0;
         screen_id      <= '0;
         game_on        <= 1'b0;
         mode_sel       <= '0;
         level_sel      <= LEVEL_W'(1);
         lives_left     <= 4'(START_LIVES);
         game_over_type <= '0;
         score_reset    <= 1'b0;
         lives_reset    <= 1'b0;
         level_start    <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         key_d          <= key_raw;
         press_q        <= key_raw & ~key_d;
         RGBOut         <= rgb_nxt;
         screen_id      <= screen_nxt;
         game_on        <= game_on_nxt;
         mode_sel       <= mode_nxt;
         level_sel      <= level_nxt;
         lives_left     <= lives_nxt;
         game_over_type <= type_nxt;
         score_reset    <= score_reset_nxt;
         lives_reset    <= lives_reset_nxt;
         level_start    <= level_start_nxt;
      end
   end

   // Next state and next output values
   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      game_on_nxt     = game_on;
      mode_nxt        = mode_sel;
      level_nxt       = level_sel;
      lives_nxt       = lives_left;
      type_nxt        = game_over_type;
      score_reset_nxt = 1'b0;
      lives_reset_nxt = 1'b0;
      level_start_nxt = 1'b0;
      lives_dec       = (lives_left != 4'd0) ? lives_left - 4'd1 : 4'd0;

      case (state)
         S_MAIN: begin
            level_nxt   = LEVEL_W'(1);
            mode_nxt    = '0;
            lives_nxt   = 4'(START_LIVES);
            game_on_nxt = 1'b0;
            if (enter_p) begin
               state_nxt       = S_MODE;
               score_reset_nxt = 1'b1;
               lives_reset_nxt = 1'b1;
            end
         end
         S_MODE: begin
            // Simultaneous up and down cancel out
            if (down_p && !up_p)
               mode_nxt = (mode_sel == MODE_MAX) ? '0 : mode_sel + MODE_W'(1);
            else if (up_p && !down_p)
               mode_nxt = (mode_sel == '0) ? MODE_MAX : mode_sel - MODE_W'(1);
            if (enter_p)
               state_nxt = S_CONTROLS;
         end
         S_CONTROLS: begin
            if (enter_p) begin
               state_nxt       = S_LEVEL;
               cnt_nxt         = CNT_W'(SPLASH_SEC);
               level_start_nxt = 1'b1;
            end
         end
         S_LEVEL: begin
            if (cnt == '0) begin
               state_nxt   = S_PLAY;
               game_on_nxt = 1'b1;
            end else if (one_sec_pulse) begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_PLAY: begin
            if (pause_p) begin
               state_nxt   = S_PAUSE;
               game_on_nxt = 1'b0;
            end else if (player_died) begin
               state_nxt = S_DYING;
               cnt_nxt   = CNT_W'(DEATH_SEC);
            end else if (timer_ended) begin
               state_nxt   = S_OVER;
               type_nxt    = 2'd0;
               game_on_nxt = 1'b0;
            end else if (level_done) begin
               game_on_nxt = 1'b0;
               if (level_sel < LEVEL_MAX) begin
                  state_nxt       = S_LEVEL;
                  level_nxt       = level_sel + LEVEL_W'(1);
                  cnt_nxt         = CNT_W'(SPLASH_SEC);
                  level_start_nxt = 1'b1;
               end else begin
                  state_nxt = S_WON;
               end
            end
         end
         S_PAUSE: begin
            if (pause_p || enter_p) begin
               state_nxt   = S_PLAY;
               game_on_nxt = 1'b1;
            end
         end
         S_DYING: begin
            if (cnt == '0) begin
               game_on_nxt = 1'b0;
               if (mode_sel == MODE_MAX && NUM_MODES > 1) begin
                  state_nxt = S_OVER;
                  type_nxt  = 2'd2;
               end else begin
                  lives_nxt = lives_dec;
                  if (lives_dec == 4'd0) begin
                     state_nxt = S_OVER;
                     type_nxt  = 2'd1;
                  end else begin
                     state_nxt       = S_LEVEL;
                     cnt_nxt         = CNT_W'(SPLASH_SEC);
                     level_start_nxt = 1'b1;
                  end
               end
            end else if (one_sec_pulse) begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_OVER, S_WON: begin
            if (enter_p) begin
               state_nxt       = S_MAIN;
               lives_reset_nxt = 1'b1;
               level_nxt       = LEVEL_W'(1);
               mode_nxt        = '0;
               lives_nxt       = 4'(START_LIVES);
            end
         end
         default: begin
            state_nxt   = S_MAIN;
            game_on_nxt = 1'b0;
         end
      endcase

      // Screen id follows the state being entered so it stays aligned with state
      case (state_nxt)
         S_MAIN:     screen_nxt = 3'd0;
         S_MODE:     screen_nxt = 3'd1;
         S_CONTROLS: screen_nxt = 3'd2;
         S_LEVEL:    screen_nxt = 3'd3;
         S_OVER:     screen_nxt = 3'd4;
         S_WON:      screen_nxt = 3'd5;
         S_PAUSE:    screen_nxt = 3'd6;
         default:    screen_nxt = 3'd7;
      endcase
   end

endmodule

// File: tb/tb_game_flow_sm.sv
// tb_game_flow_sm: randomized scenario bench for game_flow_sm against a
// screen-level behavioural model of the game flow rules.
module tb_game_flow_sm;

   localparam int NL = 3;
   localparam int NM = 2;
   localparam int SL = 2;
   localparam int SS = 2;
   localparam int DS = 2;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        enter_key = 1'b0, up_key = 1'b0, down_key = 1'b0, pause_key = 1'b0;
   logic        one_sec_pulse = 1'b0;
   logic        timer_ended = 1'b0, player_died = 1'b0, level_done = 1'b0;
   logic [6:0]  screen_DR = '0;
   logic [55:0] screen_RGB = '0;
   logic [7:0]  RGB_MIF = '0;
   logic [7:0]  RGBOut;
   logic [2:0]  screen_id;
   logic        game_on;
   logic [0:0]  mode_sel;
   logic [1:0]  level_sel;
   logic [3:0]  lives_left;
   logic [1:0]  game_over_type;
   logic        score_reset, lives_reset, level_start;

   int n_cmp = 0;
   int n_bad = 0;
   int ls_cnt = 0;

   // Model of the visible game status
   int   m_screen, m_level, m_mode, m_lives, m_type;
   logic m_on;

   game_flow_sm #(
      .NUM_LEVELS(NL), .NUM_MODES(NM), .START_LIVES(SL),
      .SPLASH_SEC(SS), .DEATH_SEC(DS)
   ) dut (
      .clk(clk), .resetN(resetN),
      .enter_key(enter_key), .up_key(up_key), .down_key(down_key), .pause_key(pause_key),
      .one_sec_pulse(one_sec_pulse),
      .timer_ended(timer_ended), .player_died(player_died), .level_done(level_done),
      .screen_DR(screen_DR), .screen_RGB(screen_RGB), .RGB_MIF(RGB_MIF),
      .RGBOut(RGBOut), .screen_id(screen_id), .game_on(game_on),
      .mode_sel(mode_sel), .level_sel(level_sel), .lives_left(lives_left),
      .game_over_type(game_over_type),
      .score_reset(score_reset), .lives_reset(lives_reset), .level_start(level_start)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (level_start) ls_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [12:0] obs();
      return {screen_id, game_on, level_sel, lives_left, mode_sel, game_over_type};
   endfunction

   function automatic logic [12:0] expv();
      return {3'(m_screen), m_on, 2'(m_level), 4'(m_lives), 1'(m_mode), 2'(m_type)};
   endfunction

   function automatic logic [2:0] strobes();
      return {score_reset, lives_reset, level_start};
   endfunction

   task automatic model_reset();
      m_screen = 0; m_level = 1; m_mode = 0; m_lives = SL; m_type = 0; m_on = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // k: 0 enter, 1 up, 2 down, 3 pause; returns two cycles after the key rises
   task automatic press(input int k);
      case (k)
         0: enter_key = 1'b1;
         1: up_key    = 1'b1;
         2: down_key  = 1'b1;
         default: pause_key = 1'b1;
      endcase
      step();
      enter_key = 1'b0; up_key = 1'b0; down_key = 1'b0; pause_key = 1'b0;
      step();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) step();
         one_sec_pulse = 1'b1;
         step();
         one_sec_pulse = 1'b0;
      end
   endtask

   task automatic walk_to_play(input int mode);
      press(0);
      for (int i = 0; i < mode; i++) press(2);
      press(0);
      press(0);
      ticks(SS);
      step();
      m_screen = 7; m_on = 1'b1; m_mode = mode;
   endtask

   // Death outcome after the delay, from the game rules
   task automatic model_death();
      m_on = 1'b0;
      if (m_mode == NM - 1) begin
         m_screen = 4; m_type = 2;
      end else begin
         if (m_lives > 0) m_lives--;
         if (m_lives == 0) begin m_screen = 4; m_type = 1; end
         else m_screen = 3;
      end
   endtask

   task automatic test_reset();
      model_reset();
      enter_key = 1'b1;
      resetN = 1'b0;
      step(); step();
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL reset_state: got %h want %h", obs(), expv()); end
      n_cmp++;
      if ({RGBOut, strobes()} !== 11'h000) begin n_bad++; $display("FAIL reset_rgb_strobes: got %h want 000", {RGBOut, strobes()}); end
      resetN = 1'b1;
      repeat (4) step();
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL held_key_ignored: got %h want %h", obs(), expv()); end
      enter_key = 1'b0;
      step();
   endtask

   task automatic test_rgb_mux();
      logic [7:0] v, w;
      for (int i = 0; i < 5; i++) begin
         v = (i == 0) ? 8'hE0 : 8'($urandom);
         w = 8'($urandom);
         screen_RGB = {48'($urandom) ^ {16'($urandom), 32'($urandom)}, v};
         screen_DR = 7'($urandom) | 7'h01;
         RGB_MIF = w;
         step();
         n_cmp++;
         if (RGBOut !== v) begin n_bad++; $display("FAIL rgb_screen0: got %h want %h", RGBOut, v); end
         screen_DR = 7'($urandom) & 7'h7E;
         step();
         n_cmp++;
         if (RGBOut !== w) begin n_bad++; $display("FAIL rgb_mif: got %h want %h", RGBOut, w); end
      end
      screen_DR = '0; RGB_MIF = '0; screen_RGB = '0;
   endtask

   task automatic test_menu_walk_and_mode();
      logic [7:0] v;
      press(0);
      m_screen = 1;
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL menu_to_mode: got %h want %h", obs(), expv()); end
      n_cmp++;
      if (strobes() !== 3'b110) begin n_bad++; $display("FAIL menu_strobes: got %b want 110", strobes()); end
      step();
      n_cmp++;
      if (strobes() !== 3'b000) begin n_bad++; $display("FAIL menu_strobes_clear: got %b want 000", strobes()); end

      // Mode screen pixel through screen 1
      v = 8'($urandom);
      screen_RGB = '0; screen_RGB[15:8] = v; screen_DR = 7'h02; RGB_MIF = ~v;
      step();
      n_cmp++;
      if (RGBOut !== v) begin n_bad++; $display("FAIL rgb_screen1: got %h want %h", RGBOut, v); end
      screen_DR = '0;

      press(2); m_mode = (m_mode + 1) % NM;
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL mode_down1: got %h want %h", obs(), expv()); end
      press(2); m_mode = (m_mode + 1) % NM;
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL mode_down2: got %h want %h", obs(), expv()); end
      press(1); m_mode = (m_mode + NM - 1) % NM;
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL mode_up: got %h want %h", obs(), expv()); end

      down_key = 1'b1;
      repeat (50) step();
      down_key = 1'b0;
      step();
      m_mode = (m_mode + 1) % NM;
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL mode_hold: got %h want %h", obs(), expv()); end

      up_key = 1'b1; down_key = 1'b1;
      step();
      up_key = 1'b0; down_key = 1'b0;
      step(); step();
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL mode_both: got %h want %h", obs(), expv()); end

      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 1) == 1) begin press(2); m_mode = (m_mode + 1) % NM; end
         else begin press(1); m_mode = (m_mode + NM - 1) % NM; end
         repeat ($urandom_range(0, 2)) step();
         n_cmp++;
         if (obs() !== expv()) begin n_bad++; $display("FAIL mode_random%0d: got %h want %h", i, obs(), expv()); end
      end
      for (int i = 0; i < NM && m_mode != 0; i++) begin
         press(2); m_mode = (m_mode + 1) % NM;
      end

      press(0); m_screen = 2;
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL menu_to_controls: got %h want %h", obs(), expv()); end
      ls_cnt = 0;
      press(0); m_screen = 3;
      n_cmp++;
      if (obs() !== expv() || strobes() !== 3'b001) begin
         n_bad++; $display("FAIL menu_to_level: got %h/%b want %h/001", obs(), strobes(), expv());
      end
      ticks(SS);
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL splash_hold: got %h want %h", obs(), expv()); end
      step();
      m_screen = 7; m_on = 1'b1;
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL splash_to_play: got %h want %h", obs(), expv()); end
      n_cmp++;
      if (ls_cnt !== 1) begin n_bad++; $display("FAIL level_start_count: got %0d want 1", ls_cnt); end

      // Gameplay has no screen: background pixel even with every draw request set
      screen_DR = 7'h7F; screen_RGB = {7{8'hAA}}; RGB_MIF = 8'h5C;
      step();
      n_cmp++;
      if (RGBOut !== 8'h5C) begin n_bad++; $display("FAIL rgb_play_mif: got %h want 5c", RGBOut); end
      screen_DR = '0; RGB_MIF = '0;
   endtask

   task automatic test_priority();
      pause_key = 1'b1;
      step();
      pause_key = 1'b0; player_died = 1'b1;
      step();
      player_died = 1'b0;
      m_screen = 6; m_on = 1'b0;
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL pause_over_death: got %h want %h", obs(), expv()); end

      player_died = 1'b1; timer_ended = 1'b1; level_done = 1'b1;
      repeat ($urandom_range(3, 8)) step();
      player_died = 1'b0; timer_ended = 1'b0; level_done = 1'b0;
      step();
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL pause_ignores_events: got %h want %h", obs(), expv()); end

      press(($urandom_range(0, 1) == 1) ? 3 : 0);
      m_screen = 7; m_on = 1'b1;
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL pause_resume: got %h want %h", obs(), expv()); end

      player_died = 1'b1; timer_ended = 1'b1;
      step();
      player_died = 1'b0; timer_ended = 1'b0;
      ticks(DS);
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL death_over_timer: got %h want %h", obs(), expv()); end
      step();
      model_death();
      n_cmp++;
      if (obs() !== expv() || strobes() !== 3'b001) begin
         n_bad++; $display("FAIL death_retry: got %h/%b want %h/001", obs(), strobes(), expv());
      end
      ticks(SS);
      step();
      m_screen = 7; m_on = 1'b1;
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL retry_play: got %h want %h", obs(), expv()); end
   endtask

   task automatic test_lives_out();
      player_died = 1'b1;
      step();
      player_died = 1'b0;
      ticks(DS);
      step();
      model_death();
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL lives_over: got %h want %h", obs(), expv()); end
      press(0);
      model_reset(); m_type = 1;
      n_cmp++;
      if (obs() !== expv() || strobes() !== 3'b010) begin
         n_bad++; $display("FAIL over_to_main: got %h/%b want %h/010", obs(), strobes(), expv());
      end
      step();
      n_cmp++;
      if (strobes() !== 3'b000) begin n_bad++; $display("FAIL over_strobe_clear: got %b want 000", strobes()); end
   endtask

   task automatic test_progression();
      walk_to_play(0);
      for (int lv = 1; lv <= NL; lv++) begin
         repeat ($urandom_range(0, 5)) step();
         level_done = 1'b1;
         step();
         level_done = 1'b0;
         m_on = 1'b0;
         if (m_level < NL) begin
            m_level++; m_screen = 3;
            n_cmp++;
            if (obs() !== expv() || strobes() !== 3'b001) begin
               n_bad++; $display("FAIL level_up%0d: got %h/%b want %h/001", lv, obs(), strobes(), expv());
            end
            ticks(SS);
            step();
            m_screen = 7; m_on = 1'b1;
         end else begin
            m_screen = 5;
            n_cmp++;
            if (obs() !== expv()) begin n_bad++; $display("FAIL game_won: got %h want %h", obs(), expv()); end
         end
      end
      press(0);
      model_reset(); m_type = 1;
      n_cmp++;
      if (obs() !== expv() || strobes() !== 3'b010) begin
         n_bad++; $display("FAIL won_to_main: got %h/%b want %h/010", obs(), strobes(), expv());
      end
      step();
      n_cmp++;
      if (lives_reset !== 1'b0) begin n_bad++; $display("FAIL won_strobe_clear: got %b want 0", lives_reset); end
   endtask

   task automatic test_over_types();
      walk_to_play(NM - 1);
      player_died = 1'b1;
      step();
      player_died = 1'b0;
      ticks(DS);
      step();
      model_death();
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL two_player_over: got %h want %h", obs(), expv()); end
      press(0);
      model_reset(); m_type = 2;
      walk_to_play(0);
      timer_ended = 1'b1;
      step();
      timer_ended = 1'b0;
      m_screen = 4; m_type = 0; m_on = 1'b0;
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL timer_over: got %h want %h", obs(), expv()); end
      press(0);
      model_reset();
   endtask

   task automatic test_reset_mid_game();
      walk_to_play($urandom_range(0, NM - 1));
      level_done = 1'b1;
      step();
      level_done = 1'b0;
      RGB_MIF = 8'h3C;
      step();
      resetN = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if (obs() !== expv() || strobes() !== 3'b000 || RGBOut !== 8'h00) begin
         n_bad++; $display("FAIL async_reset: got %h/%b/%h want %h/000/00", obs(), strobes(), RGBOut, expv());
      end
      step();
      resetN = 1'b1;
      RGB_MIF = '0;
      step(); step();
      n_cmp++;
      if (obs() !== expv() || strobes() !== 3'b000) begin
         n_bad++; $display("FAIL after_reset: got %h/%b want %h/000", obs(), strobes(), expv());
      end
   endtask

   initial begin
      test_reset();
      test_rgb_mux();
      test_menu_walk_and_mode();
      test_priority();
      test_lives_out();
      test_progression();
      test_over_types();
      test_reset_mid_game();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
